// File: rtl/flash_read_framer_if.sv
//------------------------------------------------------------------------------
// flash_read_framer_if : byte-FIFO pop port and framed output stream
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface flash_read_framer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_req;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read_req, out_data, out_valid
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read_req, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/flash_read_framer.sv
//------------------------------------------------------------------------------
// flash_read_framer : drains the flash byte FIFO into SYNC/SEQ/LEN/payload
// frames; optional trailing XOR byte when FRAME_CHECKSUM_EN is defined.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flash_read_framer #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        system_clk,
  input  logic        system_reset,
  input  logic        start,
  input  logic [31:0] total_bytes,
  flash_read_framer_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] FRAME_LEN_W = 32'(FRAME_LEN);
  localparam logic [7:0]  FRAME_LEN_B = 8'(FRAME_LEN);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SYNC = 4'd1,
    S_SEQ  = 4'd2,
    S_LEN  = 4'd3,
    S_POP  = 4'd4,
    S_WAIT = 4'd5,
    S_PAY  = 4'd6,
    S_FIN  = 4'd7
`ifdef FRAME_CHECKSUM_EN
    , S_CHK = 4'd8
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif
  logic [7:0]  len_w;

  // remaining is frozen through the header, so LEN can be derived live
  assign len_w = (remaining_q < FRAME_LEN_W) ? remaining_q[7:0] : FRAME_LEN_B;

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
`ifdef FRAME_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    remaining_d       = remaining_q;
    cnt_d             = cnt_q;
    seq_d             = seq_q;
    data_d            = data_q;
    frame_cnt_d       = frame_cnt_q;
`ifdef FRAME_CHECKSUM_EN
    chk_d             = chk_q;
`endif
    bus.fifo_read_req = 1'b0;
    bus.out_valid     = 1'b0;
    bus.out_data      = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = total_bytes;
          seq_d       = 8'h00;
          frame_cnt_d = 16'h0000;
          state_d     = (total_bytes == 32'd0) ? S_FIN : S_SYNC;
        end
      end
      S_SYNC: begin
        bus.out_valid = 1'b1;
        bus.out_data  = SYNC_BYTE;
`ifdef FRAME_CHECKSUM_EN
        chk_d         = 8'h00;
`endif
        if (bus.out_ready) state_d = S_SEQ;
      end
      S_SEQ: begin
        bus.out_valid = 1'b1;
        bus.out_data  = seq_q;
        if (bus.out_ready) begin
`ifdef FRAME_CHECKSUM_EN
          chk_d   = chk_q ^ seq_q;
`endif
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = len_w;
        if (bus.out_ready) begin
          cnt_d   = len_w;
`ifdef FRAME_CHECKSUM_EN
          chk_d   = chk_q ^ len_w;
`endif
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (!bus.fifo_empty) begin
          bus.fifo_read_req = 1'b1;
          state_d           = S_WAIT;
        end
      end
      S_WAIT: begin
        data_d  = bus.fifo_data;
        state_d = S_PAY;
      end
      S_PAY: begin
        bus.out_valid = 1'b1;
        bus.out_data  = data_q;
        if (bus.out_ready) begin
          remaining_d = remaining_q - 32'd1;
          cnt_d       = cnt_q - 8'd1;
`ifdef FRAME_CHECKSUM_EN
          chk_d       = chk_q ^ data_q;
          state_d     = (cnt_q == 8'd1) ? S_CHK : S_POP;
`else
          if (cnt_q == 8'd1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            seq_d       = seq_q + 8'd1;
            state_d     = (remaining_q == 32'd1) ? S_FIN : S_SYNC;
          end else begin
            state_d = S_POP;
          end
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHK: begin
        bus.out_valid = 1'b1;
        bus.out_data  = chk_q;
        if (bus.out_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          seq_d       = seq_q + 8'd1;
          state_d     = (remaining_q == 32'd0) ? S_FIN : S_SYNC;
        end
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_read_framer.sv
//------------------------------------------------------------------------------
// tb_flash_read_framer : directed self-checking bench for flash_read_framer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_flash_read_framer;

  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] total_bytes;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  flash_read_framer_if bus ();

  flash_read_framer #(
    .FRAME_LEN (FL),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .system_clk   (clk),
    .system_reset (rst),
    .start        (start),
    .total_bytes  (total_bytes),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .frame_cnt    (frame_cnt)
  );

  // FIFO model: memory filled by the stimulus, read pointer owned by the pop logic
  logic [7:0] fifo_mem [0:1023];
  logic [9:0] wr_ptr = '0;
  logic [9:0] rd_ptr = '0;
  logic       force_empty;

  assign bus.fifo_empty = (rd_ptr == wr_ptr) || force_empty;

  logic [7:0] rx_mem [0:1023];
  logic [9:0] rx_cnt        = '0;
  int         pop_cnt       = 0;
  int         empty_pop_err = 0;
  int         hold_err      = 0;
  int         done_cnt      = 0;
  logic       hold_pend     = 1'b0;
  logic [7:0] hold_data     = 8'h00;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.fifo_read_req) begin
        pop_cnt <= pop_cnt + 1;
        if (bus.fifo_empty) begin
          empty_pop_err <= empty_pop_err + 1;
        end else begin
          bus.fifo_data <= fifo_mem[rd_ptr];
          rd_ptr        <= rd_ptr + 10'd1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        rx_mem[rx_cnt] <= bus.out_data;
        rx_cnt         <= rx_cnt + 10'd1;
      end
      if (hold_pend && (!bus.out_valid || bus.out_data != hold_data))
        hold_err <= hold_err + 1;
      hold_pend <= bus.out_valid && !bus.out_ready;
      hold_data <= bus.out_data;
      if (done) done_cnt <= done_cnt + 1;
    end else begin
      hold_pend <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_mem [0:1023];
  int         exp_cnt;

  task automatic put_exp(input logic [7:0] b);
    exp_mem[exp_cnt] = b;
    exp_cnt++;
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  // Reference framing of `total` payload bytes read from fifo_mem starting at `src`
  task automatic build_exp(input int total, input int src);
    int         rem;
    int         k;
    logic [7:0] seq;
    logic [7:0] len;
    logic [7:0] x;
    rem = total;
    k   = src;
    seq = 8'h00;
    exp_cnt = 0;
    while (rem > 0) begin
      len = (rem < FL) ? 8'(rem) : 8'(FL);
      put_exp(8'hA5);
      put_exp(seq);
      put_exp(len);
      x = seq ^ len;
      for (int i = 0; i < int'(len); i++) begin
        put_exp(fifo_mem[10'(k)]);
        x = x ^ fifo_mem[10'(k)];
        k++;
      end
`ifdef FRAME_CHECKSUM_EN
      put_exp(x);
`endif
      rem = rem - int'(len);
      seq = seq + 8'd1;
    end
  endtask

  task automatic compare_rx(input string tag, input int base);
    check_value({tag, "_count"}, 32'(int'(rx_cnt) - base), 32'(exp_cnt));
    for (int i = 0; i < exp_cnt; i++)
      check_value($sformatf("%s_byte%0d", tag, i), {24'h0, rx_mem[10'(base + i)]}, {24'h0, exp_mem[i]});
  endtask

  task automatic start_xfer(input logic [31:0] n);
    @(negedge clk);
    total_bytes = n;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Waits for done; optionally stalls ready, forces FIFO empty, or fires a stray start
  task automatic run_to_done(input int limit, input int rdy_at, input int emp_at,
                             input int busy_start_at, input int base, output bit ok);
    bit r_done;
    bit e_done;
    bit b_done;
    r_done = 1'b0;
    e_done = 1'b0;
    b_done = 1'b0;
    ok     = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!r_done && int'(rx_cnt) - base == rdy_at) begin
        r_done = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
      if (!e_done && int'(rx_cnt) - base == emp_at) begin
        e_done = 1'b1;
        force_empty = 1'b1;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          check_value($sformatf("no_pop_empty%0d", j), {31'h0, bus.fifo_read_req}, 32'h0);
        end
        force_empty = 1'b0;
      end
      if (!b_done && int'(rx_cnt) - base == busy_start_at) begin
        b_done = 1'b1;
        total_bytes = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] lit [6];
    int         base;
    int         pbase;
    int         dbase;
    int         src;
    bit         ok;

    lit = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    rst           = 1'b1;
    start         = 1'b0;
    total_bytes   = 32'd0;
    bus.out_ready = 1'b1;
    force_empty   = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_value("rst_read_req",  {31'h0, bus.fifo_read_req}, 32'h0);
    check_value("rst_out_data",  {24'h0, bus.out_data}, 32'h0);
    check_value("rst_busy",      {31'h0, busy}, 32'h0);
    check_value("rst_done",      {31'h0, done}, 32'h0);
    check_value("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    rst = 1'b0;

    // 3 bytes, single short frame
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) put_exp(lit[i]);
`ifdef FRAME_CHECKSUM_EN
    put_exp(8'h03);
`endif
    base = int'(rx_cnt); pbase = pop_cnt; dbase = done_cnt;
    start_xfer(32'd3);
    check_value("t1_busy", {31'h0, busy}, 32'h1);
    run_to_done(300, -1, -1, -1, base, ok);
    check_value("t1_done_seen", {31'h0, ok}, 32'h1);
    check_value("t1_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    compare_rx("t1", base);
    @(negedge clk);
    check_value("t1_done_pulse", {31'h0, done}, 32'h0);
    check_value("t1_busy_end", {31'h0, busy}, 32'h0);
    check_value("t1_pops", 32'(pop_cnt - pbase), 32'd3);
    check_value("t1_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // 20 bytes -> 16 + 4, with a start pulse while busy that must be ignored
    src = int'(wr_ptr);
    for (int i = 0; i < 20; i++) push_fifo(8'(8'h40 + i));
    build_exp(20, src);
    base = int'(rx_cnt); pbase = pop_cnt; dbase = done_cnt;
    start_xfer(32'd20);
    run_to_done(600, -1, -1, 10, base, ok);
    check_value("t2_done_seen", {31'h0, ok}, 32'h1);
    check_value("t2_frame_cnt", {16'h0, frame_cnt}, 32'd2);
    compare_rx("t2", base);
    @(negedge clk);
    check_value("t2_pops", 32'(pop_cnt - pbase), 32'd20);
    check_value("t2_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // 8 bytes with a 5-cycle ready stall and a 10-cycle FIFO-empty stall
    src = int'(wr_ptr);
    for (int i = 0; i < 8; i++) push_fifo(8'(8'h80 + 7 * i));
    build_exp(8, src);
    base = int'(rx_cnt); pbase = pop_cnt;
    start_xfer(32'd8);
    run_to_done(600, 5, 8, -1, base, ok);
    check_value("t3_done_seen", {31'h0, ok}, 32'h1);
    check_value("t3_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    compare_rx("t3", base);
    check_value("t3_pops", 32'(pop_cnt - pbase), 32'd8);
    check_value("t3_hold_err", 32'(hold_err), 32'd0);
    check_value("t3_empty_pop", 32'(empty_pop_err), 32'd0);

    // zero-length transfer
    repeat (2) @(negedge clk);
    base = int'(rx_cnt); dbase = done_cnt;
    start_xfer(32'd0);
    check_value("t4_done", {31'h0, done}, 32'h1);
    check_value("t4_busy", {31'h0, busy}, 32'h1);
    check_value("t4_valid", {31'h0, bus.out_valid}, 32'h0);
    @(negedge clk);
    check_value("t4_done_off", {31'h0, done}, 32'h0);
    check_value("t4_busy_off", {31'h0, busy}, 32'h0);
    check_value("t4_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    check_value("t4_no_bytes", 32'(int'(rx_cnt) - base), 32'd0);
    check_value("t4_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // reset mid-payload, then a fresh 1-byte transfer
    for (int i = 0; i < 10; i++) push_fifo(8'(8'hC0 + i));
    base = int'(rx_cnt);
    start_xfer(32'd10);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (int'(rx_cnt) - base == 5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_value("t5_reached_mid", {31'h0, ok}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_value("t5_rst_busy", {31'h0, busy}, 32'h0);
    check_value("t5_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check_value("t5_rst_req", {31'h0, bus.fifo_read_req}, 32'h0);
    rst = 1'b0;
    wr_ptr = rd_ptr;
    src = int'(wr_ptr);
    push_fifo(8'h77);
    build_exp(1, src);
    base = int'(rx_cnt); pbase = pop_cnt;
    start_xfer(32'd1);
    run_to_done(300, -1, -1, -1, base, ok);
    check_value("t5_done_seen", {31'h0, ok}, 32'h1);
    check_value("t5_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    compare_rx("t5", base);
    check_value("t5_pops", 32'(pop_cnt - pbase), 32'd1);
    check_value("end_hold_err", 32'(hold_err), 32'd0);
    check_value("end_empty_pop", 32'(empty_pop_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
